// File: rtl/riscv_cache_writebuffer_if.sv
// riscv_cache_writebuffer_if: push, drain and forwarding signals of the cache write buffer
interface riscv_cache_writebuffer_if #(
  parameter int XLEN       = 32,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  parameter int IDX_BITS   = $clog2(SIZE*1024*8/BLOCK_SIZE/WAYS)
);
  logic                invalidate_i;
  logic                wr_req_i;
  logic [IDX_BITS-1:0] wr_idx_i;
  logic [WAYS-1:0]     wr_way_i;
  logic [XLEN-1:0]     wr_data_i;
  logic [XLEN/8-1:0]   wr_be_i;
  logic                full_o;
  logic                empty_o;
  logic                mem_we_o;
  logic [IDX_BITS-1:0] mem_idx_o;
  logic [WAYS-1:0]     mem_way_o;
  logic [XLEN-1:0]     mem_data_o;
  logic [XLEN/8-1:0]   mem_be_o;
  logic                mem_gnt_i;
  logic [IDX_BITS-1:0] rd_idx_i;
  logic [WAYS-1:0]     rd_way_i;
  logic [XLEN/8-1:0]   fwd_be_o;
  logic [XLEN-1:0]     fwd_data_o;
  modport slave (
    input  invalidate_i, wr_req_i, wr_idx_i, wr_way_i, wr_data_i, wr_be_i, mem_gnt_i, rd_idx_i, rd_way_i,
    output full_o, empty_o, mem_we_o, mem_idx_o, mem_way_o, mem_data_o, mem_be_o, fwd_be_o, fwd_data_o
  );
  modport master (
    output invalidate_i, wr_req_i, wr_idx_i, wr_way_i, wr_data_i, wr_be_i, mem_gnt_i, rd_idx_i, rd_way_i,
    input  full_o, empty_o, mem_we_o, mem_idx_o, mem_way_o, mem_data_o, mem_be_o, fwd_be_o, fwd_data_o
  );
endinterface

// File: rtl/riscv_cache_writebuffer.sv
// riscv_cache_writebuffer: in-order store buffer feeding the cache data memory, with byte forwarding to loads.
// Defining RV_CACHE_WB_MERGE_EN lets a push to the youngest entry's idx/way merge into it.
module riscv_cache_writebuffer #(
  parameter int XLEN       = 32,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  parameter int DEPTH      = 4
) (
  input logic clk_i,
  input logic rst_i,
  riscv_cache_writebuffer_if.slave bus
);
  localparam int IDX_BITS = $clog2(SIZE*1024*8/BLOCK_SIZE/WAYS);
  localparam int PW = $clog2(DEPTH);
  localparam int NB = XLEN/8;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of 2 and at least 2");
  end
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [PW:0]         r_count;
  logic [DEPTH-1:0]    r_valid;
  logic [IDX_BITS-1:0] r_idx  [DEPTH];
  logic [WAYS-1:0]     r_way  [DEPTH];
  logic [XLEN-1:0]     r_data [DEPTH];
  logic [NB-1:0]       r_be   [DEPTH];
  logic                w_head, w_pop, w_alloc, w_merge;
  logic [PW-1:0]       w_e;
  logic [NB-1:0]       w_fwd_be;
  logic [XLEN-1:0]     w_fwd_data;
  assign w_head = r_valid[r_rd_ptr];
  assign w_pop  = w_head && bus.mem_gnt_i;
`ifdef RV_CACHE_WB_MERGE_EN
  logic [PW-1:0] w_last;
  assign w_last  = r_wr_ptr - PW'(1);
  // a head leaving this cycle cannot absorb the push, so it allocates instead
  assign w_merge = bus.wr_req_i && r_valid[w_last] && r_idx[w_last] == bus.wr_idx_i &&
                   r_way[w_last] == bus.wr_way_i && !(w_pop && w_last == r_rd_ptr);
`else
  assign w_merge = 1'b0;
`endif
  assign w_alloc = bus.wr_req_i && !bus.full_o && !w_merge;
  assign bus.full_o     = r_count == FULL_CNT;
  assign bus.empty_o    = r_count == '0;
  assign bus.mem_we_o   = w_head;
  assign bus.mem_idx_o  = w_head ? r_idx[r_rd_ptr]  : '0;
  assign bus.mem_way_o  = w_head ? r_way[r_rd_ptr]  : '0;
  assign bus.mem_data_o = w_head ? r_data[r_rd_ptr] : '0;
  assign bus.mem_be_o   = w_head ? r_be[r_rd_ptr]   : '0;
  assign bus.fwd_be_o   = w_fwd_be;
  assign bus.fwd_data_o = w_fwd_data;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else if (bus.invalidate_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + (PW+1)'(w_alloc) - (PW+1)'(w_pop);
    end
  always_ff @(posedge clk_i)
    if (w_alloc) begin
      r_idx[r_wr_ptr]  <= bus.wr_idx_i;
      r_way[r_wr_ptr]  <= bus.wr_way_i;
      r_data[r_wr_ptr] <= bus.wr_data_i;
      r_be[r_wr_ptr]   <= bus.wr_be_i;
    end
`ifdef RV_CACHE_WB_MERGE_EN
    else if (w_merge) begin
      for (int b = 0; b < NB; b++)
        if (bus.wr_be_i[b]) r_data[w_last][8*b +: 8] <= bus.wr_data_i[8*b +: 8];
      r_be[w_last] <= r_be[w_last] | bus.wr_be_i;
    end
`endif
  // walk oldest to youngest so later matches overwrite earlier bytes
  always_comb begin
    w_fwd_be   = '0;
    w_fwd_data = '0;
    w_e        = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_e = r_rd_ptr + PW'(i);
      if (r_valid[w_e] && r_idx[w_e] == bus.rd_idx_i && r_way[w_e] == bus.rd_way_i)
        for (int b = 0; b < NB; b++)
          if (r_be[w_e][b]) begin
            w_fwd_be[b]            = 1'b1;
            w_fwd_data[8*b +: 8]   = r_data[w_e][8*b +: 8];
          end
    end
  end
endmodule

// File: tb/tb_riscv_cache_writebuffer.sv
// tb_riscv_cache_writebuffer: vector table, corner sequences and random run against a queue model
module tb_riscv_cache_writebuffer;
  localparam int IDX_BITS = $clog2(64*1024*8/32/2);
  localparam int DEPTH = 4;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef struct { idx_t idx; logic [1:0] way; logic [31:0] data; logic [3:0] be; } ent_t;
  typedef struct {
    int req, idx, data, be, gnt, inv, ridx, rway;
    int efull, eempty, ewe, emidx, emdata, efbe, efdata;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  ent_t q[$];
  int got[$];
  riscv_cache_writebuffer_if wb();
  riscv_cache_writebuffer dut (.clk_i(clk), .rst_i(rst), .bus(wb));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic drive(input int req, input int idx, input int way, input int data, input int be,
                       input int gnt, input int inv, input int ridx, input int rway);
    wb.wr_req_i     = req[0];
    wb.wr_idx_i     = idx_t'(idx);
    wb.wr_way_i     = way[1:0];
    wb.wr_data_i    = data;
    wb.wr_be_i      = be[3:0];
    wb.mem_gnt_i    = gnt[0];
    wb.invalidate_i = inv[0];
    wb.rd_idx_i     = idx_t'(ridx);
    wb.rd_way_i     = rway[1:0];
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int idx, input int data, input int be);
    drive(1, idx, 1, data, be, 0, 0, 0, 0);
    tick();
  endtask
  task automatic drain(input int limit);
    got.delete();
    for (int k = 0; k < limit; k++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
      #3;
      if (wb.empty_o) break;
      got.push_back(int'(wb.mem_idx_o));
      tick();
    end
    tick();
  endtask
  task automatic add(input int req, input int idx, input int data, input int be, input int gnt, input int inv,
                     input int ridx, input int rway, input int efull, input int eempty, input int ewe,
                     input int emidx, input int emdata, input int efbe, input int efdata);
    vec_t v;
    v = '{req, idx, data, be, gnt, inv, ridx, rway, efull, eempty, ewe, emidx, emdata, efbe, efdata};
    vecs.push_back(v);
  endtask
  logic r_req, r_gnt, r_inv, pop, mrg, alloc;
  int r_idx, r_way, r_data, r_be, r_ridx, r_rway;
  logic [3:0] efbe;
  logic [31:0] efd;
  ent_t t;
  ent_t head;
  int merged_data;
  initial begin
`ifdef RV_CACHE_WB_MERGE_EN
    merged_data = 32'hAABB1122;
`else
    merged_data = 32'hAABBCCDD;
`endif
    add(1, 1, 32'h11111111, 4'hF, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 32'h22222222, 4'hF, 0, 0, 1, 1, 0, 0, 1, 1, 32'h11111111, 4'hF, 32'h11111111);
    add(1, 3, 32'h33333333, 4'hF, 0, 0, 1, 1, 0, 0, 1, 1, 32'h11111111, 4'hF, 32'h11111111);
    add(1, 4, 32'h44444444, 4'hF, 0, 0, 4, 1, 0, 0, 1, 1, 32'h11111111, 0, 0);
    add(1, 5, 32'h55555555, 4'hF, 0, 0, 4, 1, 1, 0, 1, 1, 32'h11111111, 4'hF, 32'h44444444);
    add(0, 0, 0, 0, 1, 0, 5, 1, 1, 0, 1, 1, 32'h11111111, 0, 0);
    add(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 1, 2, 32'h22222222, 4'hF, 32'h22222222);
    add(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 1, 3, 32'h33333333, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4, 1, 0, 0, 1, 4, 32'h44444444, 4'hF, 32'h44444444);
    add(0, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 5, 32'hAABBCCDD, 4'hF, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 5, 32'h00001122, 4'h3, 0, 0, 5, 1, 0, 0, 1, 5, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD);
    add(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 5, merged_data, 4'hF, 32'hAABB1122);
    add(0, 0, 0, 0, 0, 0, 5, 2, 0, 0, 1, 5, merged_data, 0, 0);
    add(1, 6, 32'h66666666, 4'hF, 1, 1, 5, 1, 0, 0, 1, 5, merged_data, 4'hF, 32'hAABB1122);
    add(0, 0, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("reset_empty", wb.empty_o, 1);
    chk("reset_full", wb.full_o, 0);
    chk("reset_we", wb.mem_we_o, 0);
    chk("reset_fwd_be", wb.fwd_be_o, 0);
    chk("reset_mem_data", wb.mem_data_o, 0);
    tick();
    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].idx, 1, vecs[i].data, vecs[i].be, vecs[i].gnt, vecs[i].inv, vecs[i].ridx, vecs[i].rway);
      #3;
      chk($sformatf("vec%0d_full", i), wb.full_o, vecs[i].efull[0]);
      chk($sformatf("vec%0d_empty", i), wb.empty_o, vecs[i].eempty[0]);
      chk($sformatf("vec%0d_we", i), wb.mem_we_o, vecs[i].ewe[0]);
      chk($sformatf("vec%0d_mem_idx", i), 32'(wb.mem_idx_o), vecs[i].emidx);
      chk($sformatf("vec%0d_mem_data", i), wb.mem_data_o, vecs[i].emdata);
      chk($sformatf("vec%0d_fwd_be", i), 32'(wb.fwd_be_o), vecs[i].efbe);
      chk($sformatf("vec%0d_fwd_data", i), wb.fwd_data_o, vecs[i].efdata);
      tick();
    end
    for (int i = 0; i < 4; i++) push(17 + i, i, 4'hF);
    drive(1, 9, 1, 32'h99999999, 4'hF, 1, 0, 0, 0);
    #3;
    chk("fullpop_full_before", wb.full_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("fullpop_full_after", wb.full_o, 0);
    tick();
    drain(8);
    chk("fullpop_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("fullpop_order%0d", i), got[i], 18 + i);
    push(1, 1, 4'hF);
    push(2, 2, 4'hF);
    drive(1, 3, 1, 3, 4'hF, 1, 1, 0, 0);
    #3;
    chk("inv_we_before", wb.mem_we_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("inv_empty", wb.empty_o, 1);
    chk("inv_we", wb.mem_we_o, 0);
    chk("inv_full", wb.full_o, 0);
    tick();
    push(1, 1, 4'hF);
    push(2, 2, 4'hF);
    push(3, 3, 4'hF);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    #3;
    chk("rst_mid_head", 32'(wb.mem_idx_o), 1);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("rst_async_empty", wb.empty_o, 1);
    chk("rst_async_we", wb.mem_we_o, 0);
    chk("rst_async_idx", 32'(wb.mem_idx_o), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    push(7, 32'h12345678, 4'h1);
    push(7, 32'h0000AB00, 4'h2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
`ifdef RV_CACHE_WB_MERGE_EN
    chk("merge_be", 32'(wb.mem_be_o), 4'h3);
    chk("merge_data", 32'(wb.mem_data_o[15:0]), 16'hAB78);
    tick();
    drain(8);
    chk("merge_count", got.size(), 1);
`else
    chk("merge_be", 32'(wb.mem_be_o), 4'h1);
    chk("merge_data", 32'(wb.mem_data_o[15:0]), 16'h5678);
    tick();
    drain(8);
    chk("merge_count", got.size(), 2);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      r_req = $urandom_range(0, 9) < 6;
      r_idx = $urandom_range(0, 3);
      r_way = $urandom_range(0, 1) ? 1 : 2;
      r_data = $urandom;
      r_be = $urandom_range(0, 15);
      r_gnt = $urandom_range(0, 2) == 0;
      r_inv = $urandom_range(0, 59) == 0;
      r_ridx = $urandom_range(0, 3);
      r_rway = $urandom_range(0, 1) ? 1 : 2;
      drive(int'(r_req), r_idx, r_way, r_data, r_be, int'(r_gnt), int'(r_inv), r_ridx, r_rway);
      #3;
      head = q.size() > 0 ? q[0] : '{'0, '0, '0, '0};
      efbe = '0;
      efd = '0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].idx == idx_t'(r_ridx) && q[i].way == r_rway[1:0])
          for (int b = 0; b < 4; b++)
            if (q[i].be[b] && !efbe[b]) begin
              efbe[b] = 1'b1;
              efd[8*b +: 8] = q[i].data[8*b +: 8];
            end
      chk($sformatf("rnd%0d_full", c), wb.full_o, q.size() == DEPTH);
      chk($sformatf("rnd%0d_empty", c), wb.empty_o, q.size() == 0);
      chk($sformatf("rnd%0d_we", c), wb.mem_we_o, q.size() > 0);
      chk($sformatf("rnd%0d_mem_idx", c), 32'(wb.mem_idx_o), 32'(head.idx));
      chk($sformatf("rnd%0d_mem_way", c), 32'(wb.mem_way_o), 32'(head.way));
      chk($sformatf("rnd%0d_mem_data", c), wb.mem_data_o, head.data);
      chk($sformatf("rnd%0d_mem_be", c), 32'(wb.mem_be_o), 32'(head.be));
      chk($sformatf("rnd%0d_fwd_be", c), 32'(wb.fwd_be_o), 32'(efbe));
      chk($sformatf("rnd%0d_fwd_data", c), wb.fwd_data_o, efd);
      if (r_inv) q.delete();
      else begin
        pop = q.size() > 0 && r_gnt;
        mrg = 1'b0;
`ifdef RV_CACHE_WB_MERGE_EN
        mrg = r_req && q.size() > 0 && q[q.size()-1].idx == idx_t'(r_idx) &&
              q[q.size()-1].way == r_way[1:0] && !(pop && q.size() == 1);
`endif
        if (mrg) begin
          t = q[q.size()-1];
          for (int b = 0; b < 4; b++) if (r_be[b]) t.data[8*b +: 8] = r_data[8*b +: 8];
          t.be = t.be | r_be[3:0];
          q[q.size()-1] = t;
        end
        alloc = r_req && q.size() < DEPTH && !mrg;
        if (pop) void'(q.pop_front());
        if (alloc) q.push_back('{idx_t'(r_idx), r_way[1:0], r_data, r_be[3:0]});
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
endmodule

// File: doc/riscv_cache_writebuffer.md
Name: riscv_cache_writebuffer

Overview:
- Store buffer between the cache address setup stage and the cache data memory.
- Takes hit-confirmed cacheable writes (index, way, data, byte-enables) from the setup/hit stages into a small in-order FIFO.
- Drains entries to the data-memory write port whenever the port is granted.
- Gives the read path byte-wise forwarding of pending data so loads never see stale memory contents.

Parameters:
- XLEN, 32, data/address width.
- SIZE, 64, cache size in KBytes; IDX_BITS is derived exactly as in the other cache stages (no_of_sets / no_of_index_bits).
- BLOCK_SIZE, XLEN, cache block size in bits.
- WAYS, 2, associativity; way select is one-hot, WAYS bits.
- DEPTH, 4, buffer entries; must be a power of 2 and ≥2.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- invalidate_i  in  1  discard all pending entries (cache invalidate).
- wr_req_i  in  1  write request.
- wr_idx_i  in  IDX_BITS  set index.
- wr_way_i  in  WAYS  one-hot way.
- wr_data_i  in  XLEN  write data.
- wr_be_i  in  XLEN/8  byte enables.
- full_o  out  1  buffer full; a request in this cycle is not accepted.
- empty_o  out  1  no valid entries.
- mem_we_o  out  1  head entry valid, write requested.
- mem_idx_o  out  IDX_BITS  head index.
- mem_way_o  out  WAYS  head way.
- mem_data_o  out  XLEN  head data.
- mem_be_o  out  XLEN/8  head byte enables.
- mem_gnt_i  in  1  data-memory write port accepts head this cycle.
- rd_idx_i  in  IDX_BITS  lookup index from read path.
- rd_way_i  in  WAYS  lookup way.
- fwd_be_o  out  XLEN/8  bytes supplied by the buffer.
- fwd_data_o  out  XLEN  forwarded bytes; bytes not flagged in fwd_be_o are 0.

Behaviour:
- Reset (rst_i=1, any time, including mid-drain):
  - rd/wr pointers and count = 0.
  - All valid bits = 0; empty_o=1, full_o=0, mem_we_o=0.
  - mem_* data, fwd_* = 0.
  - Entry payload storage need not be reset.
- Storage is a circular FIFO: wr_ptr/rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- full_o = (count==DEPTH); empty_o = (count==0). Both come from registered state only.
- Push: wr_req_i && !full_o.
  - Writes the entry at wr_ptr, sets its valid bit, increments wr_ptr.
  - A request while full_o=1 is ignored. The upstream stage must stall and hold the request.
- Pop: mem_we_o && mem_gnt_i.
  - Clears the head valid bit and increments rd_ptr.
  - mem_* always show the head entry combinationally from storage.
  - mem_gnt_i while empty has no effect.
- Latency: a write pushed in cycle N appears on mem_* in cycle N+1 at the earliest.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, the pop does not enable a same-cycle push; full_o is registered state.
  - When empty, the pushed entry cannot pop in the same cycle.
- invalidate_i has priority over push and pop in the same cycle: the next state is empty.
- Forwarding (combinational), for each byte b:
  - Over valid entries with idx==rd_idx_i, way==rd_way_i and be[b]=1, select the youngest entry (closest to wr_ptr).
  - fwd_be_o[b]=1 and fwd_data_o byte b = that entry's byte.
  - Only registered entries are searched; the write presented this cycle is not.
  - The head being popped this cycle still forwards in that cycle.
- Ordering: entries drain strictly in push order and no entry is reordered.

Optional Feature:
- Macro: RV_CACHE_WB_MERGE_EN.
- Defined: a push whose idx/way matches the youngest valid entry (wr_ptr-1) merges into it instead of allocating.
  - Merge: data bytes with wr_be_i set are overwritten; be |= wr_be_i.
  - Merge is allowed when full.
  - Merge is suppressed if that entry is the head and is being popped this cycle; the push then allocates normally.
- Undefined: every accepted push allocates a new entry.

Test Plan:
- Reset and idle:
  - Stimulus: rst_i pulse, then idle.
  - Response: empty_o=1, full_o=0, mem_we_o=0, fwd_be_o=0 with rd_idx_i=0.
- Fill to full:
  - Stimulus: 4 pushes with mem_gnt_i=0, idx=1..4, data=0x11111111·idx, be=0xF; then a 5th push.
  - Response: full_o=1 after the 4th push; the 5th is ignored.
  - Then mem_gnt_i=1 for 4 cycles → mem_idx_o sequence 1,2,3,4 in order, then empty_o=1.
- Forwarding, youngest byte wins:
  - Stimulus: push idx=5 way=01 data=0xAABBCCDD be=0xF; then push idx=5 way=01 data=0x00001122 be=0x3; hold drain; lookup rd_idx_i=5 rd_way_i=01.
  - Response: fwd_be_o=0xF, fwd_data_o=0xAABB1122. With rd_way_i=10 → fwd_be_o=0.
- Full with simultaneous pop and push:
  - Stimulus: full buffer, mem_gnt_i=1 and wr_req_i=1 in the same cycle.
  - Response: the push is ignored; the next cycle has count=3 and full_o=0.
- Invalidate and reset mid-operation:
  - Stimulus: 2 entries, invalidate_i=1 together with a push and a grant.
  - Response: next cycle empty_o=1, mem_we_o=0.
  - Repeat with rst_i asserted mid-drain → same result, asynchronously.
- Merge, RV_CACHE_WB_MERGE_EN defined:
  - Stimulus: push idx=7 data=0x12345678 be=0x1, then push idx=7 data=0x0000AB00 be=0x2, drain disabled.
  - Response: count=1, head be=0x3, head data byte0=0x78, byte1=0xAB.
  - Macro undefined → count=2.
